// File: rtl/pio_sample_sched.sv
// Periodic sampler for a 16-bit input PIO: samples into a FIFO, host reads via a 4-register slave.
// Define PIO_SAMPLE_TIMESTAMP_EN to store a 16-bit cycle timestamp alongside each sample.
module pio_sample_sched #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [15:0] PERIOD_RST = 16'd100
) (
   input  logic        clk,
   input  logic        reset,
   output logic [1:0]  pio_address,
   input  logic [15:0] pio_readdata,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [15:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
`ifdef PIO_SAMPLE_TIMESTAMP_EN
   localparam int unsigned FW = 32;
`else
   localparam int unsigned FW = 16;
`endif

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_CAPT = 2'd2, S_PUSH = 2'd3} state_t;

   state_t                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d, per_act_q, per_act_d, period_q, period_d;
   logic [15:0]           last_q, last_d, per_eff_s;
   logic [2:0]            ctrl_q, ctrl_d;
   logic                  ovf_q, ovf_d, first_q, first_d, irq_q, irq_d;
   logic [FW-1:0]         sample_q, sample_d, cap_s;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [1:0]            pio_address_q, pio_address_d;
   logic [31:0]           readdata_q, readdata_d, head_s;
   logic                  en_s, tick_s, want_push_s, keep_s, push_s, pop_s, full_s, empty_s, ovf_set_s;
   logic [FW-1:0]         mem_q [DEPTH];

`ifdef PIO_SAMPLE_TIMESTAMP_EN
   logic [15:0] ts_q, ts_d;

   // Free-running timestamp, captured together with the PIO data
   always_comb begin
      ts_d  = ts_q + 16'd1;
      cap_s = {ts_q, pio_readdata};
   end

   // Timestamp register
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_q <= 16'd0;
      end else begin
         ts_q <= ts_d;
      end
   end
`else
   // Capture word is the bare PIO data
   always_comb begin
      cap_s = pio_readdata;
   end
`endif

   assign en_s    = ctrl_q[0];
   assign full_s  = (count_q == CW'(DEPTH));
   assign empty_s = (count_q == CW'(0));
   assign head_s  = 32'(mem_q[rd_ptr_q]);

   // Prescaler; a newly written PERIOD is only picked up on a wrap so a running interval is never cut short
   always_comb begin
      per_eff_s = (per_act_q == 16'd0) ? 16'd1 : per_act_q;
      tick_s    = 1'b0;
      cnt_d     = cnt_q;
      per_act_d = per_act_q;
      if (!en_s) begin
         cnt_d     = 16'd0;
         per_act_d = period_q;
      end else if (cnt_q >= per_eff_s - 16'd1) begin
         cnt_d     = 16'd0;
         tick_s    = 1'b1;
         per_act_d = period_q;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Sampling sequence; clearing EN aborts it and discards the in-flight sample
   always_comb begin
      state_d     = state_q;
      sample_d    = sample_q;
      want_push_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick_s) begin
               state_d = S_ADDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: state_d = S_CAPT;
         S_CAPT: begin
            state_d  = S_PUSH;
            sample_d = cap_s;
         end
         S_PUSH: begin
            state_d     = S_IDLE;
            want_push_s = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (!en_s) begin
         state_d     = S_IDLE;
         want_push_s = 1'b0;
      end else begin
         state_d = state_d;
      end
      pio_address_d = (state_d == S_ADDR) ? 2'd0 : 2'd3;
   end

   // FIFO bookkeeping: a pop frees the slot for a same-cycle push, so full+pop+push never overflows
   always_comb begin
      keep_s    = want_push_s && (first_q || !ctrl_q[1] || (sample_q[15:0] != last_q));
      pop_s     = read && (address == 2'd0) && !empty_s;
      push_s    = keep_s && (!full_s || pop_s);
      ovf_set_s = keep_s && full_s && !pop_s;
      wr_ptr_d  = push_s ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d  = pop_s ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
      last_d    = push_s ? sample_q[15:0] : last_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (!en_s) begin
         first_d = 1'b1;
      end else if (push_s) begin
         first_d = 1'b0;
      end else begin
         first_d = first_q;
      end
   end

   // Host register slave
   always_comb begin
      ctrl_d     = (write && address == 2'd2) ? writedata[2:0] : ctrl_q;
      period_d   = (write && address == 2'd3) ? writedata : period_q;
      readdata_d = readdata_q;
      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (write && address == 2'd1 && writedata[15]) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if (read) begin
         case (address)
            2'd0:    readdata_d = pop_s ? head_s : 32'd0;
            2'd1:    readdata_d = {16'h0000, ovf_q, full_s, empty_s, 4'h0, 9'(count_q)};
            2'd2:    readdata_d = {29'd0, ctrl_q};
            2'd3:    readdata_d = {16'h0000, period_q};
            default: readdata_d = 32'd0;
         endcase
      end else begin
         readdata_d = readdata_q;
      end
      irq_d = (count_d != CW'(0)) && ctrl_d[2];
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= 16'd0;
         per_act_q     <= PERIOD_RST;
         period_q      <= PERIOD_RST;
         ctrl_q        <= 3'd0;
         ovf_q         <= 1'b0;
         first_q       <= 1'b1;
         last_q        <= 16'd0;
         sample_q      <= {FW{1'b0}};
         wr_ptr_q      <= {DEPTH_LOG2{1'b0}};
         rd_ptr_q      <= {DEPTH_LOG2{1'b0}};
         count_q       <= {CW{1'b0}};
         pio_address_q <= 2'd3;
         readdata_q    <= 32'd0;
         irq_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         per_act_q     <= per_act_d;
         period_q      <= period_d;
         ctrl_q        <= ctrl_d;
         ovf_q         <= ovf_d;
         first_q       <= first_d;
         last_q        <= last_d;
         sample_q      <= sample_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         pio_address_q <= pio_address_d;
         readdata_q    <= readdata_d;
         irq_q         <= irq_d;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= sample_q;
      end
   end

   assign pio_address = pio_address_q;
   assign readdata    = readdata_q;
   assign irq         = irq_q;
endmodule

// File: tb/tb_pio_sample_sched.sv
// Bench for pio_sample_sched: two instances (depth 16 and depth 4) share host stimulus;
// expectations come from a queue-based model of sampling, filtering and overflow rules.
module tb_pio_sample_sched;
   logic        clk = 1'b0;
   logic        reset, read, write;
   logic [1:0]  address, pio_address_a, pio_address_b;
   logic [15:0] writedata, pio_rd_a, pio_rd_b, pio_const, pio_v;
   logic [31:0] readdata_a, readdata_b, da, db;
   logic        irq_a, irq_b;
   int          n_cmp = 0, n_err = 0;
   int          ev_a = 0, ev_b = 0, pio_rd = 0, pio_wr = 0;
   logic [15:0] pio_tab [1024];
   logic [15:0] rvals [64];
   logic [15:0] qa[$], qb[$];

   always #5 clk = ~clk;

   pio_sample_sched #(.DEPTH_LOG2(4), .PERIOD_RST(16'd100)) dut_a (
      .clk(clk), .reset(reset), .pio_address(pio_address_a), .pio_readdata(pio_rd_a),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .readdata(readdata_a), .irq(irq_a));

   pio_sample_sched #(.DEPTH_LOG2(2), .PERIOD_RST(16'd100)) dut_b (
      .clk(clk), .reset(reset), .pio_address(pio_address_b), .pio_readdata(pio_rd_b),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .readdata(readdata_b), .irq(irq_b));

   // PIO slave model: data at address 0 one cycle later, next value from the table per sample
   always @(posedge clk) begin
      pio_v = pio_const;
      if (pio_address_a == 2'd0 || pio_address_b == 2'd0) begin
         if (pio_rd < pio_wr) begin
            pio_v  = pio_tab[pio_rd % 1024];
            pio_rd = pio_rd + 1;
         end
      end
      pio_rd_a <= (pio_address_a == 2'd0) ? pio_v : 16'h0000;
      pio_rd_b <= (pio_address_b == 2'd0) ? pio_v : 16'h0000;
      if (pio_address_a == 2'd0) ev_a = ev_a + 1;
      if (pio_address_b == 2'd0) ev_b = ev_b + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dmask(input logic [31:0] d);
`ifdef PIO_SAMPLE_TIMESTAMP_EN
      return {16'h0000, d[15:0]};
`else
      return d;
`endif
   endfunction

   function automatic logic [31:0] st(input bit ovf, input int cnt, input int depth);
      return {16'h0000, ovf, (cnt == depth), (cnt == 0), 4'h0, 9'(cnt)};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] ra, output logic [31:0] rb);
      address = a; read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      ra = readdata_a; rb = readdata_b;
   endtask

   task automatic flush();
      pio_wr = pio_rd;
   endtask

   task automatic load(input logic [15:0] v);
      pio_tab[pio_wr % 1024] = v;
      pio_wr = pio_wr + 1;
   endtask

   // Enable for exactly n sample intervals, then disable after the n-th push completes
   task automatic run(input int p, input logic [2:0] ctl, input int n);
      int ea, eb;
      wr(2'd3, 16'(p));
      ea = ev_a; eb = ev_b;
      wr(2'd2, {13'd0, ctl | 3'b001});
      idle(n * p + 3);
      wr(2'd2, {13'd0, ctl & 3'b110});
      chk("samples_a", 32'(ev_a - ea), 32'(n));
      chk("samples_b", 32'(ev_b - eb), 32'(n));
   endtask

   task automatic drain(input int n);
      logic [31:0] xa, xb;
      for (int i = 0; i < n; i++) begin
         xa = (qa.size() > 0) ? {16'h0000, qa.pop_front()} : 32'd0;
         xb = (qb.size() > 0) ? {16'h0000, qb.pop_front()} : 32'd0;
         rd(2'd0, da, db);
         chk("data_a", dmask(da), xa);
         chk("data_b", dmask(db), xb);
      end
   endtask

   task automatic status(input string tag, input logic [31:0] xa, input logic [31:0] xb);
      rd(2'd1, da, db);
      chk({tag, "_a"}, da, xa);
      chk({tag, "_b"}, db, xb);
   endtask

   // Reference: keep a sample if filtering is off, it differs from the last kept one, or it is the first
   task automatic model(input int which, input int depth, input bit chg, input int n, output bit ovf);
      bit          first = 1'b1;
      logic [15:0] last = 16'h0000;
      int          sz;
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (first || !chg || rvals[i] != last) begin
            sz = (which == 0) ? qa.size() : qb.size();
            if (sz < depth) begin
               if (which == 0) qa.push_back(rvals[i]); else qb.push_back(rvals[i]);
               last  = rvals[i];
               first = 1'b0;
            end else begin
               ovf = 1'b1;
            end
         end
      end
   endtask

   initial begin
      int          p, n;
      bit          chg, oa, ob;
      logic [15:0] prev_ts;
      reset = 1'b1; read = 1'b0; write = 1'b0; address = 2'd0; writedata = 16'h0000;
      pio_const = 16'h0000; prev_ts = 16'h0000;
      idle(3);
      reset = 1'b0;
      chk("rst_pio_addr_a", 32'(pio_address_a), 32'd3);
      chk("rst_pio_addr_b", 32'(pio_address_b), 32'd3);
      chk("rst_readdata_a", readdata_a, 32'd0);
      chk("rst_irq_a", 32'(irq_a), 32'd0);
      status("rst_status", 32'h2000, 32'h2000);
      rd(2'd2, da, db); chk("rst_ctrl_a", da, 32'd0); chk("rst_ctrl_b", db, 32'd0);
      rd(2'd3, da, db); chk("rst_period_a", da, 32'd100); chk("rst_period_b", db, 32'd100);

      // Constant input, PERIOD=10, ten samples; IE stays set afterwards
      pio_const = 16'h1234;
      run(10, 3'b100, 10);
      chk("irq_on_a", 32'(irq_a), 32'd1);
      chk("irq_on_b", 32'(irq_b), 32'd1);
      status("p10_status", 32'h000A, 32'hC004);
      for (int i = 0; i < 11; i++) begin
         rd(2'd0, da, db);
         chk("p10_data_a", dmask(da), (i < 10) ? 32'h1234 : 32'd0);
         chk("p10_data_b", dmask(db), (i < 4) ? 32'h1234 : 32'd0);
`ifdef PIO_SAMPLE_TIMESTAMP_EN
         if (i > 0 && i < 10) chk("ts_delta", 32'(da[31:16] - prev_ts), 32'd10);
         prev_ts = da[31:16];
`endif
      end
      chk("irq_off_a", 32'(irq_a), 32'd0);
      chk("irq_off_b", 32'(irq_b), 32'd0);
      wr(2'd1, 16'h8000);
      status("w1c_status", 32'h2000, 32'h2000);
      wr(2'd2, 16'h0000);

      // Change-only filtering
      flush();
      load(16'd5); load(16'd5); load(16'd5); load(16'd7); load(16'd7); load(16'd5);
      run(5, 3'b010, 6);
      status("chg_status", 32'h0003, 32'h0003);
      qa = '{16'd5, 16'd7, 16'd5}; qb = '{16'd5, 16'd7, 16'd5};
      drain(4);

      // Reset in the middle of a sampling sequence
      wr(2'd3, 16'd5); wr(2'd2, 16'h0001); idle(7);
      reset = 1'b1; idle(2); reset = 1'b0;
      status("rstmid_status", 32'h2000, 32'h2000);
      rd(2'd2, da, db); chk("rstmid_ctrl_a", da, 32'd0);
      rd(2'd3, da, db); chk("rstmid_period_b", db, 32'd100);

      // Overflow on the small FIFO, then clear OVF
      flush();
      load(16'h11); load(16'h22); load(16'h33); load(16'h44); load(16'h55);
      run(5, 3'b000, 5);
      status("ovf_status", 32'h0005, 32'hC004);
      wr(2'd1, 16'h8000);
      status("ovf_clr_status", 32'h0005, 32'h4004);
      qa = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55}; qb = '{16'h11, 16'h22, 16'h33, 16'h44};
      drain(6);

      // DATA read on the same cycle as the 5th push into a full FIFO
      flush();
      load(16'h11); load(16'h22); load(16'h33); load(16'h44); load(16'h55);
      wr(2'd3, 16'd5); wr(2'd2, 16'h0001); idle(26);
      rd(2'd0, da, db);
      chk("coinc_data_a", dmask(da), 32'h11);
      chk("coinc_data_b", dmask(db), 32'h11);
      wr(2'd2, 16'h0000);
      status("coinc_status", 32'h0004, 32'h4004);
      qa = '{16'h22, 16'h33, 16'h44, 16'h55}; qb = '{16'h22, 16'h33, 16'h44, 16'h55};
      drain(5);

      // EN cleared during ADDR; re-enable must push even an unchanged value
      flush();
      pio_const = 16'h0077;
      run(5, 3'b010, 1);
      qa = '{16'h77}; qb = '{16'h77};
      drain(2);
      wr(2'd2, 16'h0003); idle(5); wr(2'd2, 16'h0002); idle(10);
      status("abort_status", 32'h2000, 32'h2000);
      run(5, 3'b010, 1);
      status("reen_status", 32'h0001, 32'h0001);
      qa = '{16'h77}; qb = '{16'h77};
      drain(2);

      // Randomized rounds
      for (int r = 0; r < 6; r++) begin
         p   = int'($urandom_range(5, 9));
         n   = int'($urandom_range(3, 22));
         chg = 1'($urandom_range(0, 1));
         flush();
         for (int i = 0; i < n; i++) begin
            rvals[i] = 16'($urandom_range(0, 2));
            load(rvals[i]);
         end
         qa.delete(); qb.delete();
         model(0, 16, chg, n, oa);
         model(1, 4, chg, n, ob);
         run(p, chg ? 3'b010 : 3'b000, n);
         status("rnd_status", st(oa, qa.size(), 16), st(ob, qb.size(), 4));
         drain(qa.size() + 1);
         wr(2'd1, 16'h8000);
         status("rnd_end_status", 32'h2000, 32'h2000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
